cavlc_mb_sequencer: RTL and testbench
=====================================

// Module: cavlc_mb_sequencer
// PURPOSE
//  Macroblock-level controller for the CAVLC residual decoder. It launches the
//  decoder once per 4x4 block, walks NUM_BLK blocks per macroblock, and maps each
//  decoded level into a flat coefficient-buffer address. It records each block's
//  coefficient count for later nC prediction, and guards against overrun/hang.
//  It sits between the slice-level parser (MbStart) and the CAVLC decoder plus
//  the coefficient RAM.
// PARAMETERS
//  NUM_BLK    16    4x4 blocks per macroblock (16 = luma only; 24 adds chroma AC)
//  LEVEL_W    13    decoded level width; must match the decoder LevelOut width
//  TMO_CYC    1024  max cycles from CavlcStart to BlockDone before timeout
// PORTS
//  Clk            in   1                  clock
//  nReset         in   1                  async reset, active low
//  MbStart        in   1                  pulse: decode one macroblock
//  MbBusy         out  1                  high from accepted MbStart to MbDone/Err
//  MbDone         out  1                  1-cycle pulse: all NUM_BLK blocks closed
//  CavlcStart     out  1                  1-cycle pulse: decoder begins next block
//  CavlcWrReq     in   1                  decoder level valid (decoder WrReq)
//  CavlcLevel     in   LEVEL_W            decoder level (decoder LevelOut)
//  CavlcBlockDone in   1                  decoder block complete (decoder BlockDone)
//  CoefWrEn       out  1                  coefficient RAM write strobe
//  CoefWrAddr     out  $clog2(NUM_BLK)+4  {BlkIdx, CoefIdx[3:0]}
//  CoefWrData     out  LEVEL_W            registered CavlcLevel
//  BlkIdx         out  $clog2(NUM_BLK)    block currently being decoded
//  BlkDoneStb     out  1                  1-cycle pulse: block closed; BlkTotalCoeff valid
//  BlkTotalCoeff  out  5                  levels written for the closed block (0..16)
//  Err            out  1                  sticky until next accepted MbStart
//  ErrCode        out  2                  0 none, 1 overrun (>16 levels), 2 timeout
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; counters 0. Reset mid-macroblock aborts it.
//   No MbDone is issued, and the coefficient RAM contents are undefined.
//  FSM states IDLE, LAUNCH, DECODE, CLOSE, DONE, ERR.
//   IDLE   : MbStart -> LAUNCH. Clears Err/ErrCode, BlkIdx=0, MbBusy=1 next cycle.
//   LAUNCH : CavlcStart=1 for exactly one cycle; CoefIdx=0, TmoCnt=0 -> DECODE.
//   DECODE : each CavlcWrReq -> next cycle CoefWrEn=1, addr={BlkIdx,CoefIdx},
//            data=CavlcLevel; CoefIdx++ (5-bit count, no wrap).
//            CavlcBlockDone -> CLOSE.
//            A 17th CavlcWrReq in one block -> ERR, ErrCode=1, no RAM write.
//            TmoCnt reaching TMO_CYC-1 without BlockDone -> ERR, ErrCode=2.
//   CLOSE  : BlkDoneStb=1, BlkTotalCoeff=CoefIdx.
//            If BlkIdx==NUM_BLK-1 -> DONE, else BlkIdx++ -> LAUNCH.
//   DONE   : MbDone=1 for one cycle, MbBusy=0 -> IDLE.
//   ERR    : Err=1, MbBusy=0 -> IDLE. Err holds until the next accepted MbStart.
//  Latency: MbStart to first CavlcStart is 2 cycles; level to RAM write is 1 cycle.
//   CavlcBlockDone to next CavlcStart is 2 cycles (CLOSE, LAUNCH).
//  Simultaneous CavlcWrReq+CavlcBlockDone: the level is written and counted in
//   that block's total.
//  MbStart while MbBusy=1: ignored. MbStart in the same cycle as MbDone: ignored.
//  WrReq/BlockDone outside DECODE: ignored (no write, no error).
//  Zero-coefficient block (BlockDone with no WrReq): BlkTotalCoeff=0, no writes.
// STRUCTURE
//  cavlc_pkg: state enum cavlc_seq_state_e, ERR_NONE/ERR_OVERRUN/ERR_TMO
//   constants, MAX_COEF=16, LEVEL_W default.
//  Single module; no sub-module (the timeout counter stays inline).
// TESTING
//  1 All-zero MB: BlockDone 3 cycles after each CavlcStart -> 16 BlkDoneStb,
//    each with TotalCoeff 0; no CoefWrEn; MbDone 1 cycle after the 16th close.
//  2 Block 5 emits levels 3,-1,1 -> writes at addr 0x50..0x52 with data 3,0x1FFF,1;
//    BlkTotalCoeff=3.
//  3 Block 0 emits 16 levels, BlockDone concurrent with the 16th -> 16 writes,
//    TotalCoeff=16, no Err.
//  4 17 WrReq in block 2 -> Err=1, ErrCode=1, 16 writes only, MbBusy drops,
//    no MbDone.
//  5 No BlockDone after CavlcStart -> Err with ErrCode=2 at TMO_CYC cycles;
//    next MbStart clears Err and restarts at BlkIdx 0.
//  6 nReset asserted during block 7 -> all outputs 0 immediately.
//    MbStart after release -> CavlcStart 2 cycles later, BlkIdx=0.

Source files
------------

// File: rtl/cavlc_pkg.sv
// Shared types and constants for the CAVLC macroblock sequencer.
package cavlc_pkg;

  // Default decoded-level width; must track the decoder's LevelOut width.
  localparam int LEVEL_W_DEF = 13;

  // A 4x4 block carries at most 16 coefficients.
  localparam int MAX_COEF = 16;

  // Sequencer state encoding, kept as plain constants for legacy tools.
  typedef logic [2:0] cavlc_seq_state_e;
  localparam cavlc_seq_state_e ST_IDLE   = 3'd0;
  localparam cavlc_seq_state_e ST_LAUNCH = 3'd1;
  localparam cavlc_seq_state_e ST_DECODE = 3'd2;
  localparam cavlc_seq_state_e ST_CLOSE  = 3'd3;
  localparam cavlc_seq_state_e ST_DONE   = 3'd4;
  localparam cavlc_seq_state_e ST_ERR    = 3'd5;

  // Error codes reported on ErrCode.
  typedef logic [1:0] cavlc_err_e;
  localparam cavlc_err_e ERR_NONE    = 2'd0;
  localparam cavlc_err_e ERR_OVERRUN = 2'd1;
  localparam cavlc_err_e ERR_TMO     = 2'd2;

endpackage

// File: rtl/cavlc_mb_sequencer.sv
// Macroblock-level controller for the CAVLC residual decoder: launches one
// decode per 4x4 block, maps decoded levels to coefficient-RAM addresses,
// reports per-block coefficient counts and guards against overrun and hang.
module cavlc_mb_sequencer
  import cavlc_pkg::*;
#(
  parameter int NUM_BLK = 16,
  parameter int LEVEL_W = LEVEL_W_DEF,
  parameter int TMO_CYC = 1024
) (
  input  logic                        Clk,
  input  logic                        nReset,
  input  logic                        MbStart,
  output logic                        MbBusy,
  output logic                        MbDone,
  output logic                        CavlcStart,
  input  logic                        CavlcWrReq,
  input  logic [LEVEL_W-1:0]          CavlcLevel,
  input  logic                        CavlcBlockDone,
  output logic                        CoefWrEn,
  output logic [$clog2(NUM_BLK)+3:0]  CoefWrAddr,
  output logic [LEVEL_W-1:0]          CoefWrData,
  output logic [$clog2(NUM_BLK)-1:0]  BlkIdx,
  output logic                        BlkDoneStb,
  output logic [4:0]                  BlkTotalCoeff,
  output logic                        Err,
  output logic [1:0]                  ErrCode
);

  localparam int BLK_W  = $clog2(NUM_BLK);
  localparam int ADDR_W = BLK_W + 4;
  localparam int TMO_W  = $clog2(TMO_CYC + 1);

  cavlc_seq_state_e   state_q, state_d;
  logic               mb_start_q, mb_start_d;   // accepted MbStart, one cycle
  logic [BLK_W-1:0]   blk_idx_q, blk_idx_d;
  logic [4:0]         coef_idx_q, coef_idx_d;   // 0..16, never wraps
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [LEVEL_W-1:0] wr_data_q, wr_data_d;
  logic               err_q, err_d;
  cavlc_err_e         err_code_q, err_code_d;

  // Next-state, counter, write-port and error logic.
  always_comb begin
    // NOTE: every target gets a default first so no path can infer a latch.
    state_d    = state_q;
    mb_start_d = 1'b0;
    blk_idx_d  = blk_idx_q;
    coef_idx_d = coef_idx_q;
    tmo_cnt_d  = tmo_cnt_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    err_d      = err_q;
    err_code_d = err_code_q;

    case (state_q)
      ST_IDLE: begin
        // MbStart is registered once so the first launch lands two cycles
        // after the request, matching the block-to-block cadence.
        if (mb_start_q) begin
          state_d = ST_LAUNCH;
        end else if (MbStart) begin
          mb_start_d = 1'b1;
          blk_idx_d  = '0;
          err_d      = 1'b0;
          err_code_d = ERR_NONE;
        end
      end
      ST_LAUNCH: begin
        coef_idx_d = '0;
        tmo_cnt_d  = '0;
        state_d    = ST_DECODE;
      end
      ST_DECODE: begin
        if (CavlcWrReq && (coef_idx_q == 5'(MAX_COEF))) begin
          // A 17th level cannot belong to a 4x4 block; drop it and abort.
          state_d    = ST_ERR;
          err_d      = 1'b1;
          err_code_d = ERR_OVERRUN;
        end else begin
          if (CavlcWrReq) begin
            wr_en_d    = 1'b1;
            wr_addr_d  = {blk_idx_q, coef_idx_q[3:0]};
            wr_data_d  = CavlcLevel;
            coef_idx_d = coef_idx_q + 5'd1;
          end
          // BlockDone wins over a timeout in the same cycle.
          if (CavlcBlockDone) begin
            state_d = ST_CLOSE;
          end else if (tmo_cnt_q == TMO_W'(TMO_CYC - 1)) begin
            state_d    = ST_ERR;
            err_d      = 1'b1;
            err_code_d = ERR_TMO;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
          end
        end
      end
      ST_CLOSE: begin
        if (blk_idx_q == BLK_W'(NUM_BLK - 1)) begin
          state_d = ST_DONE;
        end else begin
          blk_idx_d = blk_idx_q + BLK_W'(1);
          state_d   = ST_LAUNCH;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any macroblock in flight.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q    <= ST_IDLE;
      mb_start_q <= 1'b0;
      blk_idx_q  <= '0;
      coef_idx_q <= '0;
      tmo_cnt_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      // NOTE: non-blocking so every flop updates from pre-edge values.
      state_q    <= state_d;
      mb_start_q <= mb_start_d;
      blk_idx_q  <= blk_idx_d;
      coef_idx_q <= coef_idx_d;
      tmo_cnt_q  <= tmo_cnt_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign MbBusy        = mb_start_q || (state_q == ST_LAUNCH) ||
                         (state_q == ST_DECODE) || (state_q == ST_CLOSE);
  assign MbDone        = (state_q == ST_DONE);
  assign CavlcStart    = (state_q == ST_LAUNCH);
  assign BlkDoneStb    = (state_q == ST_CLOSE);
  assign BlkTotalCoeff = (state_q == ST_CLOSE) ? coef_idx_q : 5'd0;
  assign BlkIdx        = blk_idx_q;
  assign CoefWrEn      = wr_en_q;
  assign CoefWrAddr    = wr_addr_q;
  assign CoefWrData    = wr_data_q;
  assign Err           = err_q;
  assign ErrCode       = err_code_q;

endmodule

// File: tb/tb_cavlc_mb_sequencer.sv
// Scoreboard bench for cavlc_mb_sequencer: the driver plays a decoder model
// against directed per-block scripts and queues the expected output events;
// a negedge monitor pops and compares each event as the DUT presents it.
module tb_cavlc_mb_sequencer;

  localparam int NUM_BLK = 16;
  localparam int LEVEL_W = 13;
  localparam int TMO_CYC = 1024;

  localparam int EV_WR  = 0;
  localparam int EV_BLK = 1;
  localparam int EV_MB  = 2;
  localparam int EV_ERR = 3;

  logic               Clk = 1'b0;
  logic               nReset;
  logic               MbStart;
  logic               MbBusy;
  logic               MbDone;
  logic               CavlcStart;
  logic               CavlcWrReq;
  logic [LEVEL_W-1:0] CavlcLevel;
  logic               CavlcBlockDone;
  logic               CoefWrEn;
  logic [7:0]         CoefWrAddr;
  logic [LEVEL_W-1:0] CoefWrData;
  logic [3:0]         BlkIdx;
  logic               BlkDoneStb;
  logic [4:0]         BlkTotalCoeff;
  logic               Err;
  logic [1:0]         ErrCode;

  typedef struct {
    int kind;
    int a;
    int b;
  } ev_t;

  ev_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_close_cyc = -100;
  logic err_prev = 1'b0;

  // Per-block decoder script for the macroblock being played.
  int               nlev[NUM_BLK];
  logic [LEVEL_W-1:0] lev[NUM_BLK][17];
  bit               conc[NUM_BLK];
  bit               poke_start[NUM_BLK];

  cavlc_mb_sequencer #(
    .NUM_BLK(NUM_BLK),
    .LEVEL_W(LEVEL_W),
    .TMO_CYC(TMO_CYC)
  ) dut (
    .Clk           (Clk),
    .nReset        (nReset),
    .MbStart       (MbStart),
    .MbBusy        (MbBusy),
    .MbDone        (MbDone),
    .CavlcStart    (CavlcStart),
    .CavlcWrReq    (CavlcWrReq),
    .CavlcLevel    (CavlcLevel),
    .CavlcBlockDone(CavlcBlockDone),
    .CoefWrEn      (CoefWrEn),
    .CoefWrAddr    (CoefWrAddr),
    .CoefWrData    (CoefWrData),
    .BlkIdx        (BlkIdx),
    .BlkDoneStb    (BlkDoneStb),
    .BlkTotalCoeff (BlkTotalCoeff),
    .Err           (Err),
    .ErrCode       (ErrCode)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc = cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic void push(input int kind, input int a, input int b);
    ev_t e;
    e.kind = kind;
    e.a    = a;
    e.b    = b;
    exp_q.push_back(e);
  endfunction

  task automatic sb_pop(input int kind, input int a, input int b, input string nm);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL %s: unexpected event a=0x%0h b=0x%0h, queue empty (cycle %0d)",
               nm, a, b, cyc);
    end else begin
      e = exp_q.pop_front();
      check({nm, "_kind"}, kind, e.kind);
      check({nm, "_a"}, a, e.a);
      check({nm, "_b"}, b, e.b);
    end
  endtask

  // Monitor: compare every output event against the head of the queue.
  always @(negedge Clk) begin
    if (nReset) begin
      if (CoefWrEn)
        sb_pop(EV_WR, int'(CoefWrAddr), int'(CoefWrData), "coef_wr");
      if (BlkDoneStb) begin
        sb_pop(EV_BLK, int'(BlkIdx), int'(BlkTotalCoeff), "blk_done");
        last_close_cyc = cyc;
      end
      if (MbDone) begin
        sb_pop(EV_MB, 0, 0, "mb_done");
        check("mb_done_after_close", cyc - last_close_cyc, 1);
      end
      if (Err && !err_prev)
        sb_pop(EV_ERR, int'(ErrCode), 0, "err_rise");
    end
    err_prev = Err;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_script();
    for (int b = 0; b < NUM_BLK; b++) begin
      nlev[b]       = 0;
      conc[b]       = 1'b0;
      poke_start[b] = 1'b0;
      for (int i = 0; i < 17; i++) lev[b][i] = '0;
    end
  endtask

  task automatic wait_start(output int n);
    n = 0;
    while (!CavlcStart && n < 50) begin
      tick();
      n = n + 1;
    end
    check("cavlc_start_seen", int'(CavlcStart), 1);
  endtask

  // Pulse MbStart from IDLE and check acceptance and the 2-cycle launch.
  task automatic mb_start();
    MbStart = 1'b1;
    tick();
    MbStart = 1'b0;
    check("busy_after_accept", int'(MbBusy), 1);
    check("err_cleared", int'(Err), 0);
    check("no_early_start", int'(CavlcStart), 0);
    tick();
    check("start_latency2", int'(CavlcStart), 1);
    check("start_blk0", int'(BlkIdx), 0);
  endtask

  // Play one block of the script; returns in the cycle after the last input.
  task automatic run_block(input int blk, input bit first);
    int n;
    wait_start(n);
    if (!first) check("done_to_start", n, 1);
    check("blk_idx", int'(BlkIdx), blk);
    tick();
    if (poke_start[blk]) MbStart = 1'b1;
    if (nlev[blk] == 0) begin
      tick();
      MbStart = 1'b0;
      tick();
    end
    for (int i = 0; i < nlev[blk]; i++) begin
      CavlcWrReq = 1'b1;
      CavlcLevel = lev[blk][i];
      if (i < 16) push(EV_WR, blk * 16 + i, int'(lev[blk][i]));
      else        push(EV_ERR, 1, 0);
      if (conc[blk] && i == nlev[blk] - 1) begin
        CavlcBlockDone = 1'b1;
        push(EV_BLK, blk, nlev[blk]);
      end
      tick();
      MbStart = 1'b0;
    end
    CavlcWrReq     = 1'b0;
    CavlcBlockDone = 1'b0;
    if (nlev[blk] <= 16 && !conc[blk]) begin
      CavlcBlockDone = 1'b1;
      push(EV_BLK, blk, nlev[blk]);
      tick();
      CavlcBlockDone = 1'b0;
    end
  endtask

  // Whole macroblock, then an MbStart in the MbDone cycle that must be ignored.
  task automatic run_full_mb();
    mb_start();
    for (int b = 0; b < NUM_BLK; b++) run_block(b, b == 0);
    push(EV_MB, 0, 0);
    tick();
    check("mb_done_pulse", int'(MbDone), 1);
    check("busy_low_at_done", int'(MbBusy), 0);
    MbStart = 1'b1;
    tick();
    MbStart = 1'b0;
    check("start_at_done_ignored", int'(MbBusy), 0);
    repeat (3) tick();
    check("no_restart", int'(CavlcStart), 0);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int n;
    nReset         = 1'b0;
    MbStart        = 1'b0;
    CavlcWrReq     = 1'b0;
    CavlcLevel     = '0;
    CavlcBlockDone = 1'b0;
    clear_script();

    repeat (3) @(posedge Clk);
    #1;
    check("rst_ctrl", int'({MbBusy, MbDone, CavlcStart, CoefWrEn, BlkDoneStb,
                            Err, ErrCode, BlkIdx, BlkTotalCoeff}), 0);
    check("rst_wr", int'({CoefWrAddr, CoefWrData}), 0);
    nReset = 1'b1;
    tick();
    tick();

    // All-zero macroblock.
    clear_script();
    run_full_mb();

    // Full 16-level block 0 with concurrent BlockDone; block 5 levels 3,-1,1.
    clear_script();
    nlev[0] = 16;
    conc[0] = 1'b1;
    for (int i = 0; i < 16; i++) lev[0][i] = LEVEL_W'(i + 1);
    nlev[5] = 3;
    lev[5][0] = 13'h0003;
    lev[5][1] = 13'h1FFF;
    lev[5][2] = 13'h0001;
    poke_start[1] = 1'b1;
    run_full_mb();

    // Overrun: 17 levels in block 2.
    clear_script();
    nlev[2] = 17;
    for (int i = 0; i < 17; i++) lev[2][i] = LEVEL_W'(100 + i);
    mb_start();
    run_block(0, 1'b1);
    run_block(1, 1'b0);
    run_block(2, 1'b0);
    repeat (3) tick();
    check("ovr_busy_low", int'(MbBusy), 0);
    check("ovr_err", int'(Err), 1);
    check("ovr_code", int'(ErrCode), 1);
    check("ovr_queue_drained", exp_q.size(), 0);

    // Timeout: no BlockDone after the launch of block 0.
    clear_script();
    mb_start();
    push(EV_ERR, 2, 0);
    n = 0;
    while (!Err && n < TMO_CYC + 20) begin
      tick();
      n = n + 1;
    end
    check("tmo_seen", int'(Err), 1);
    check("tmo_code", int'(ErrCode), 2);
    check("tmo_window", int'(n >= TMO_CYC && n <= TMO_CYC + 1), 1);
    check("tmo_busy_low", int'(MbBusy), 0);
    tick();

    // Restart clears Err at block 0, then reset lands mid block 7.
    mb_start();
    for (int b = 0; b < 7; b++) run_block(b, b == 0);
    wait_start(n);
    check("blk7_idx", int'(BlkIdx), 7);
    tick();
    CavlcWrReq = 1'b1;
    CavlcLevel = 13'h0005;
    #2;
    nReset = 1'b0;
    #1;
    check("rst_mid_ctrl", int'({MbBusy, MbDone, CavlcStart, CoefWrEn, BlkDoneStb,
                                Err, ErrCode, BlkIdx, BlkTotalCoeff}), 0);
    check("rst_mid_wr", int'({CoefWrAddr, CoefWrData}), 0);
    CavlcWrReq = 1'b0;
    repeat (2) @(posedge Clk);
    #3;
    nReset = 1'b1;
    tick();
    check("post_rst_idle", int'(MbBusy), 0);
    clear_script();
    run_full_mb();

    check("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
